// File: rtl/bidir_bus_pkg.sv
// Shared types and constants for the half-duplex bus controller and its timer.
// The counter width helper sizes one timer to cover both the turnaround and timeout counts.
package bidir_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bidir_bus_timer.sv
// Loadable up/down counter with zero and limit flags.
// Counts down for the turnaround gap and up for the ack wait.
module bidir_bus_timer #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_en,
    input  logic          i_up,
    input  logic [CW-1:0] i_limit,
    output logic          o_zero,
    output logic          o_at_limit
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= i_up ? (r_count + 1'b1) : (r_count - 1'b1);
        end
    end

    assign o_zero     = (r_count == '0);
    assign o_at_limit = (r_count == i_limit);

endmodule

// File: rtl/bidir_bus_ctrl.sv
// Sequencer for a shared half-duplex bus: single-word writes and reads with a strobe/ack
// handshake, turnaround gaps on direction change and an ack timeout. All outputs registered.
module bidir_bus_ctrl
    import bidir_bus_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    // Request channel: a request transfers on a rising edge where i_req_valid and o_req_ready
    // are both 1; i_req_write/i_req_data must be stable while i_req_valid is high.
    input  logic             i_req_valid,
    input  logic             i_req_write,
    input  logic [WIDTH-1:0] i_req_data,
    output logic             o_req_ready,
    output logic             o_rsp_valid,
    output logic [WIDTH-1:0] o_rsp_data,
    output logic             o_rsp_err,
    output logic             o_bus_dir,
    output logic [WIDTH-1:0] o_bus_out,
    input  logic [WIDTH-1:0] i_bus_in,
    output logic             o_bus_stb,
    input  logic             i_bus_ack,
    output state_e           o_dbg_state
);

    localparam int unsigned CW = cnt_width((TURN_CYCLES > TIMEOUT) ? TURN_CYCLES : TIMEOUT);
    localparam logic [CW-1:0] TURN_LOAD = CW'(TURN_CYCLES - 1);
    localparam logic [CW-1:0] TO_LIMIT  = CW'(TIMEOUT - 1);

    state_e           r_state, w_next;
    logic             r_write, r_last_dir;
    logic [WIDTH-1:0] r_data;
    logic             r_req_ready, r_rsp_valid, r_rsp_err, r_bus_dir, r_bus_stb;
    logic [WIDTH-1:0] r_rsp_data, r_bus_out;

    logic             w_accept, w_timeout, w_last_dir_n, w_write_n, w_drive_n;
    logic [WIDTH-1:0] w_data_n;
    logic             w_tmr_load, w_tmr_en, w_tmr_up, w_tmr_zero, w_tmr_limit;
    logic [CW-1:0]    w_tmr_load_val;

    bidir_bus_timer #(.CW(CW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_load_val),
        .i_en       (w_tmr_en),
        .i_up       (w_tmr_up),
        .i_limit    (TO_LIMIT),
        .o_zero     (w_tmr_zero),
        .o_at_limit (w_tmr_limit)
    );

    assign w_accept  = i_req_valid & r_req_ready;
    assign w_write_n = w_accept ? i_req_write : r_write;
    assign w_data_n  = w_accept ? i_req_data  : r_data;

    always_comb begin
        w_next         = r_state;
        w_tmr_load     = 1'b0;
        w_tmr_load_val = '0;
        w_tmr_en       = 1'b0;
        w_tmr_up       = 1'b0;
        w_timeout      = 1'b0;
        w_last_dir_n   = r_last_dir;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_tmr_load = 1'b1;
                    if (i_req_write != r_last_dir) begin
                        w_next         = TURN;
                        w_tmr_load_val = TURN_LOAD;
                    end else begin
                        w_next = XFER;
                    end
                end
            end
            TURN: begin
                // Leaving TURN loads 0 so the ack wait starts from a clean count.
                if (w_tmr_zero) begin
                    w_next       = XFER;
                    w_tmr_load   = 1'b1;
                    w_last_dir_n = r_write;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            XFER: begin
                if (i_bus_ack) begin
                    w_next = DONE;
                end else if (w_tmr_limit) begin
                    w_next    = DONE;
                    w_timeout = 1'b1;
                end else begin
                    w_tmr_en = 1'b1;
                    w_tmr_up = 1'b1;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // A write keeps driving through DONE as a hold cycle; IDLE and TURN always release the bus.
    always_comb begin
        w_drive_n = 1'b0;
        if (w_next == XFER) begin
            w_drive_n = w_write_n;
        end else if (w_next == DONE) begin
            w_drive_n = (w_last_dir_n == DIR_WRITE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_write     <= DIR_READ;
            r_data      <= '0;
            r_last_dir  <= DIR_READ;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            r_bus_dir   <= 1'b0;
            r_bus_stb   <= 1'b0;
            r_bus_out   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write <= i_req_write;
                r_data  <= i_req_data;
            end
            r_last_dir  <= w_last_dir_n;
            r_req_ready <= (w_next == IDLE);
            r_rsp_valid <= (w_next == DONE);
            r_rsp_err   <= w_timeout;
            r_bus_dir   <= w_drive_n;
            r_bus_stb   <= (w_next == XFER);
            r_bus_out   <= w_drive_n ? w_data_n : '0;
            if ((r_state == XFER) && i_bus_ack && !r_write) begin
                r_rsp_data <= i_bus_in;
            end
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_err   = r_rsp_err;
    assign o_rsp_data  = r_rsp_data;
    assign o_bus_dir   = r_bus_dir;
    assign o_bus_stb   = r_bus_stb;
    assign o_bus_out   = r_bus_out;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Bench for bidir_bus_ctrl: behavioural peer and bus resolution, directed scenarios,
// and a randomised transaction mix scored against a latency/outcome model.
module tb_bidir_bus_ctrl;
    import bidir_bus_pkg::*;

    localparam int W    = 8;
    localparam int TURN = 2;
    localparam int TO   = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid, req_write;
    logic [W-1:0] req_data;
    logic         req_ready, rsp_valid, rsp_err, bus_dir, bus_stb;
    logic [W-1:0] rsp_data, bus_out, bus_val;
    logic         bus_ack;
    state_e       dbg_state;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;
    int contention_cnt = 0;

    // Peer model state
    int           peer_lat  = 99;
    logic [W-1:0] peer_data = '0;
    logic         peer_w    = 1'b0;
    logic         peer_ack  = 1'b0;
    logic         peer_drive = 1'b0;
    logic         spur_ack  = 1'b0;
    int           p_cnt     = 0;
    bit           p_acked   = 1'b0;

    logic         tr_dir [0:63];
    logic         tr_stb [0:63];
    logic [W-1:0] tr_out [0:63];
    logic [W:0]   exp_q[$];

    bidir_bus_ctrl #(.WIDTH(W), .TURN_CYCLES(TURN), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (req_valid),
        .i_req_write (req_write),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_rsp_valid (rsp_valid),
        .o_rsp_data  (rsp_data),
        .o_rsp_err   (rsp_err),
        .o_bus_dir   (bus_dir),
        .o_bus_out   (bus_out),
        .i_bus_in    (bus_val),
        .o_bus_stb   (bus_stb),
        .i_bus_ack   (bus_ack),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- buffer + peer model ----------------
    assign bus_val = bus_dir ? bus_out : (peer_drive ? peer_data : 8'hEE);
    assign bus_ack = peer_ack | spur_ack;

    // Peer acks peer_lat cycles after it first sees strobe; drives data only on read acks.
    always @(negedge clk) begin
        if (!bus_stb) begin
            p_cnt = 0; p_acked = 1'b0; peer_ack = 1'b0; peer_drive = 1'b0;
        end else if (p_acked) begin
            peer_ack = 1'b0; peer_drive = 1'b0;
        end else if (p_cnt == peer_lat) begin
            peer_ack = 1'b1; peer_drive = !peer_w; p_acked = 1'b1;
        end else begin
            p_cnt++;
        end
    end

    always @(posedge clk) begin
        if (bus_dir && peer_drive) contention_cnt++;
    end

    // ---------------- driver ----------------
    task automatic do_txn(input logic w, input logic [W-1:0] d, input int lat,
                          input logic [W-1:0] pdata, output int lat_o,
                          output logic err_o, output logic [W-1:0] data_o);
        int guard;
        int acc;
        int off;
        bit done;
        for (int i = 0; i < 64; i++) begin
            tr_dir[i] = 1'b0; tr_stb[i] = 1'b0; tr_out[i] = '0;
        end
        peer_lat = lat; peer_data = pdata; peer_w = w;
        lat_o = -1; err_o = 1'bx; data_o = 'x;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk); guard++;
        end
        if (!req_ready) begin
            chk_cnt++;
            $display("FAIL ready_wait: req_ready=%0b after %0d cycles, required 1", req_ready, guard);
            return;
        end
        req_valid = 1'b1; req_write = w; req_data = d;
        acc = cyc;
        @(negedge clk);
        req_valid = 1'b0; req_data = 8'($urandom);
        done = 1'b0;
        off = 0;
        while (!done) begin
            off = cyc - acc;
            tr_dir[off] = bus_dir; tr_stb[off] = bus_stb; tr_out[off] = bus_out;
            if (rsp_valid) begin
                done = 1'b1;
            end else if (off >= 40) begin
                chk_cnt++;
                $display("FAIL rsp_wait: no rsp_valid within %0d cycles of accept", off);
                return;
            end else begin
                @(negedge clk);
            end
        end
        lat_o = off; err_o = rsp_err; data_o = rsp_data;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int g;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({bus_dir, bus_stb, req_ready, rsp_valid, rsp_err} !== 5'b0)
            $display("FAIL reset_ctl: dir/stb/rdy/vld/err=%b required 00000",
                     {bus_dir, bus_stb, req_ready, rsp_valid, rsp_err});
        else pass_cnt++;
        chk_cnt++;
        if ({bus_out, rsp_data} !== 16'h0) $display("FAIL reset_data: out/rsp_data=%h required 0000", {bus_out, rsp_data});
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk_cnt++;
        if (req_ready !== 1'b1) $display("FAIL ready_after_reset: got %b required 1", req_ready);
        else pass_cnt++;
        // Start a write then reset in its first XFER cycle.
        @(negedge clk);
        peer_lat = 99; peer_w = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_data = 8'h5A;
        @(negedge clk); req_valid = 1'b0;
        g = 0;
        while (!bus_stb && g < 10) begin @(negedge clk); g++; end
        chk_cnt++;
        if ({bus_stb, bus_dir} !== 2'b11) $display("FAIL midxfer_drive: stb/dir=%b required 11", {bus_stb, bus_dir});
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({bus_dir, bus_stb, rsp_valid, req_ready} !== 4'b0 || bus_out !== '0)
            $display("FAIL async_reset: dir/stb/vld/rdy=%b out=%h required 0000/00",
                     {bus_dir, bus_stb, rsp_valid, req_ready}, bus_out);
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk_cnt++;
        if (req_ready !== 1'b1) $display("FAIL ready_after_midreset: got %b required 1", req_ready);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_read_after_reset();
        int l; logic e; logic [W-1:0] dd;
        do_txn(1'b0, 8'h00, 1, 8'hA5, l, e, dd);
        chk_cnt++;
        if (l !== 3) $display("FAIL rd_latency: got %0d required 3", l); else pass_cnt++;
        chk_cnt++;
        if ({e, dd} !== {1'b0, 8'hA5}) $display("FAIL rd_result: err/data=%b/%h required 0/a5", e, dd); else pass_cnt++;
        chk_cnt++;
        if ({tr_stb[1], tr_dir[1], tr_dir[3]} !== 3'b100) $display("FAIL rd_no_turn: stb1/dir1/dir3=%b required 100",
                                                                {tr_stb[1], tr_dir[1], tr_dir[3]});
        else pass_cnt++;
    endtask

    task automatic test_write_after_read();
        int l; logic e; logic [W-1:0] dd;
        do_txn(1'b1, 8'h3C, 2, 8'h00, l, e, dd);
        chk_cnt++;
        if ({tr_dir[1], tr_stb[1], tr_dir[2], tr_stb[2]} !== 4'b0)
            $display("FAIL wr_turn_gap: dir/stb over gap=%b required 0000", {tr_dir[1], tr_stb[1], tr_dir[2], tr_stb[2]});
        else pass_cnt++;
        chk_cnt++;
        if ({tr_dir[3], tr_stb[3], tr_out[3]} !== {2'b11, 8'h3C})
            $display("FAIL wr_first_xfer: dir/stb=%b out=%h required 11/3c", {tr_dir[3], tr_stb[3]}, tr_out[3]);
        else pass_cnt++;
        chk_cnt++;
        if (l !== TURN + 4) $display("FAIL wr_latency: got %0d required %0d", l, TURN + 4); else pass_cnt++;
        chk_cnt++;
        if ({e, dd} !== {1'b0, 8'hA5}) $display("FAIL wr_result: err/rsp_data=%b/%h required 0/a5", e, dd); else pass_cnt++;
        chk_cnt++;
        if ({tr_dir[6], tr_stb[6]} !== 2'b10) $display("FAIL wr_hold: dir/stb in done=%b required 10", {tr_dir[6], tr_stb[6]});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int l; logic e; logic [W-1:0] dd;
        do_txn(1'b1, 8'h11, 0, 8'h00, l, e, dd);
        chk_cnt++;
        if (l !== 2 || {tr_dir[1], tr_stb[1], tr_out[1], tr_dir[2]} !== {2'b11, 8'h11, 1'b1})
            $display("FAIL b2b_first: lat=%0d dir/stb=%b out=%h hold=%b required 2/11/11/1",
                     l, {tr_dir[1], tr_stb[1]}, tr_out[1], tr_dir[2]);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if ({bus_dir, req_ready} !== 2'b01) $display("FAIL b2b_idle: dir/rdy=%b required 01", {bus_dir, req_ready});
        else pass_cnt++;
        do_txn(1'b1, 8'h22, 1, 8'h00, l, e, dd);
        chk_cnt++;
        if (l !== 3 || {tr_dir[1], tr_stb[1], tr_out[1], tr_dir[2], tr_dir[3]} !== {2'b11, 8'h22, 2'b11})
            $display("FAIL b2b_second: lat=%0d dir/stb=%b out=%h dir2/3=%b required 3/11/22/11",
                     l, {tr_dir[1], tr_stb[1]}, tr_out[1], {tr_dir[2], tr_dir[3]});
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int l; int nstb; logic e; logic [W-1:0] dd;
        @(negedge clk);
        spur_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk_cnt++;
            if ({rsp_valid, req_ready} !== 2'b01) $display("FAIL stray_ack: vld/rdy=%b required 01", {rsp_valid, req_ready});
            else pass_cnt++;
        end
        spur_ack = 1'b0;
        do_txn(1'b0, 8'h00, 99, 8'h77, l, e, dd);
        nstb = 0;
        for (int i = 0; i < 64; i++) nstb += int'(tr_stb[i]);
        chk_cnt++;
        if (nstb !== TO) $display("FAIL to_stb_cycles: got %0d required %0d", nstb, TO); else pass_cnt++;
        chk_cnt++;
        if (l !== TURN + TO + 1) $display("FAIL to_latency: got %0d required %0d", l, TURN + TO + 1); else pass_cnt++;
        chk_cnt++;
        if ({e, dd} !== {1'b1, 8'hA5}) $display("FAIL to_result: err/data=%b/%h required 1/a5", e, dd); else pass_cnt++;
    endtask

    task automatic test_random();
        logic         m_last = DIR_READ;
        logic [W-1:0] m_rdata = 8'hA5;
        logic w; logic [W-1:0] d, pd, dd; logic e;
        int lat, l, exp_lat;
        logic [W:0] exp_v;
        for (int n = 0; n < 200; n++) begin
            w   = 1'($urandom_range(0, 1));
            d   = 8'($urandom);
            pd  = 8'($urandom);
            lat = $urandom_range(0, 5);
            exp_lat = ((w != m_last) ? TURN : 0) + ((lat < TO) ? lat + 2 : TO + 1);
            if (lat >= TO) exp_q.push_back({1'b1, m_rdata});
            else if (!w) begin
                m_rdata = pd;
                exp_q.push_back({1'b0, pd});
            end else exp_q.push_back({1'b0, m_rdata});
            m_last = w;
            do_txn(w, d, lat, pd, l, e, dd);
            exp_v = exp_q.pop_front();
            chk_cnt++;
            if ({e, dd} !== exp_v) $display("FAIL rnd_rsp[%0d]: err/data=%b/%h required %b/%h", n, e, dd, exp_v[W], exp_v[W-1:0]);
            else pass_cnt++;
            chk_cnt++;
            if (l !== exp_lat) $display("FAIL rnd_latency[%0d]: got %0d required %0d", n, l, exp_lat);
            else pass_cnt++;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        chk_cnt++;
        if (contention_cnt !== 0) $display("FAIL contention: %0d cycles with both sides driving, required 0", contention_cnt);
        else pass_cnt++;
    endtask

    initial begin
        req_valid = 1'b0; req_write = 1'b0; req_data = '0;
        test_reset();
        test_read_after_reset();
        test_write_after_read();
        test_back_to_back();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
